// File: rtl/chip8_fetch_if.sv
// Decoder-side handshake bundle for chip8_fetch: opcode delivery plus the skip/jump redirect.
interface chip8_fetch_if #(
    parameter int ADDR_W = 12
);
    logic [15:0]       opcode;
    logic [ADDR_W-1:0] opcode_pc;
    logic              opcode_valid;
    logic              opcode_ready;
    logic              skip;
    logic              jmp_valid;
    logic [ADDR_W-1:0] jmp_addr;

    modport master (
        output opcode, opcode_pc, opcode_valid,
        input  opcode_ready, skip, jmp_valid, jmp_addr
    );

    modport slave (
        input  opcode, opcode_pc, opcode_valid,
        output opcode_ready, skip, jmp_valid, jmp_addr
    );
endinterface

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: two byte reads through a 1-cycle synchronous memory, big-endian opcode,
// PC ownership. Optional misaligned-fetch flag enabled by defining CHIP8_FETCH_ALIGN_CHK_EN.
module chip8_fetch #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h200
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    chip8_fetch_if.master     dec,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        ISSUE_HI,
        ISSUE_LO,
        CAPTURE_LO,
        VALID
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] pc_nx;
    logic              handshake;

    assign handshake = dec.opcode_valid & dec.opcode_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ISSUE_HI;
        else     state <= state_nx;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            ISSUE_HI:   state_nx = ISSUE_LO;
            ISSUE_LO:   state_nx = CAPTURE_LO;
            CAPTURE_LO: state_nx = VALID;
            VALID:      if (handshake) state_nx = ISSUE_HI;
            default:    state_nx = ISSUE_HI;
        endcase
    end

    always_comb begin
        mem_addr         = pc;
        dec.opcode_valid = 1'b0;
        case (state)
            ISSUE_LO: mem_addr         = pc + ADDR_W'(1);
            VALID:    dec.opcode_valid = 1'b1;
            default:  ;
        endcase
    end

    // Redirect priority: jump beats skip beats sequential; sums wrap at ADDR_W.
    always_comb begin
        pc_nx = dec.opcode_pc + ADDR_W'(2);
        if (dec.jmp_valid)  pc_nx = dec.jmp_addr;
        else if (dec.skip)  pc_nx = dec.opcode_pc + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            dec.opcode    <= 16'h0000;
            dec.opcode_pc <= RESET_PC;
        end else begin
            if (state == CAPTURE_LO) begin
                dec.opcode    <= {hi_byte, mem_data};
                dec.opcode_pc <= pc;
            end
            if (handshake) pc <= pc_nx;
        end
    end

    // NOTE: hi_byte is pure datapath, always written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ISSUE_LO) hi_byte <= mem_data;
    end

`ifdef CHIP8_FETCH_ALIGN_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst)                       err_q <= 1'b0;
        else if (state == CAPTURE_LO)  err_q <= pc[0];
        else if (handshake)            err_q <= 1'b0;
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_fetch.sv
// Scoreboarded bench for chip8_fetch: directed redirect/wrap/reset cases followed by random traffic.
module tb_chip8_fetch;
    localparam int          ADDR_W   = 12;
    localparam logic [11:0] RESET_PC = 12'h200;

    typedef struct {
        logic [11:0] pc;
        logic [15:0] op;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic [11:0] pc;
    logic        fetch_err;

    chip8_fetch_if #(.ADDR_W(ADDR_W)) dec ();

    chip8_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .dec       (dec),
        .pc        (pc),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [4096];
    always @(posedge clk) mem_data <= mem[mem_addr];

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [11:0] model_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Reference: an opcode is simply the two bytes at a and a+1 (mod 4096).
    function automatic exp_t model_fetch(input logic [11:0] a);
        exp_t        e;
        logic [11:0] a1;
        a1    = 12'((int'(a) + 1) % 4096);
        e.pc  = a;
        e.op  = {mem[a], mem[a1]};
`ifdef CHIP8_FETCH_ALIGN_CHK_EN
        e.err = a[0];
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    task automatic junk(input bit rdy);
        dec.opcode_ready = rdy;
        dec.skip         = 1'($urandom);
        dec.jmp_valid    = 1'($urandom);
        dec.jmp_addr     = 12'($urandom);
    endtask

    // All driver tasks enter and leave 1 time unit after a rising edge.
    task automatic wait_valid();
        int n = 0;
        while (dec.opcode_valid !== 1'b1) begin
            junk(1'($urandom));
            @(posedge clk); #1;
            n++;
            if (n > 16) begin
                checks++;
                errors++;
                $display("FAIL wait_valid: opcode_valid low for %0d cycles, required within 4", n);
                finish_sim();
            end
        end
        junk(1'b0);
    endtask

    task automatic handshake(input int stall, input bit s, input bit jv, input logic [11:0] ja);
        wait_valid();
        repeat (stall) begin
            junk(1'b0);
            @(posedge clk); #1;
        end
        dec.opcode_ready = 1'b1;
        dec.skip         = s;
        dec.jmp_valid    = jv;
        dec.jmp_addr     = ja;
        model_pc = jv ? ja : 12'((int'(model_pc) + (s ? 4 : 2)) % 4096);
        sb_q.push_back(model_fetch(model_pc));
        @(posedge clk); #1;
        junk(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        junk(1'b0);
        @(posedge clk); #1;
        check("rst_valid",     dec.opcode_valid, 0);
        check("rst_pc",        pc, RESET_PC);
        check("rst_opcode",    dec.opcode, 16'h0000);
        check("rst_opcode_pc", dec.opcode_pc, RESET_PC);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_mem_addr",  mem_addr, RESET_PC);
        sb_q.delete();
        model_pc = RESET_PC;
        sb_q.push_back(model_fetch(RESET_PC));
        rst = 1'b0;
    endtask

    // Monitor: compares DUT outputs with the head of the scoreboard every falling edge.
    int   cnt;
    bit   prev_valid;
    bit   prev_hs;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            cnt        = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: queue empty, required an expected fetch (t=%0t)", $time);
            end else begin
                cur = sb_q[0];
                if (prev_valid && !prev_hs) check("valid_hold", dec.opcode_valid, 1);
                if (dec.opcode_valid && !prev_valid) check("latency", cnt, 4);
                check("pc", pc, cur.pc);
                if (dec.opcode_valid) begin
                    check("opcode",    dec.opcode, cur.op);
                    check("opcode_pc", dec.opcode_pc, cur.pc);
                    check("mem_addr",  mem_addr, cur.pc);
                    check("fetch_err", fetch_err, cur.err);
                end else begin
                    check("fetch_err_idle", fetch_err, 0);
                end
                prev_hs = dec.opcode_valid && dec.opcode_ready;
                if (prev_hs) begin
                    void'(sb_q.pop_front());
                    cnt = 0;
                end
            end
            prev_valid = dec.opcode_valid;
        end
    end

    initial begin
        #1_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_sim();
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h200] = 8'h6A;
        mem[12'h201] = 8'h02;
        mem[12'hFFE] = 8'h12;
        mem[12'hFFF] = 8'h34;
        junk(1'b0);
        do_reset();

        wait_valid();
        check("t1_opcode",    dec.opcode, 16'h6A02);
        check("t1_opcode_pc", dec.opcode_pc, 12'h200);
        handshake(0, 1'b0, 1'b0, 12'h000);
        check("t1_next_pc", pc, 12'h202);

        handshake(10, 1'b0, 1'b0, 12'h000);   // 202 stalled -> 204
        handshake(0, 1'b1, 1'b0, 12'h000);    // 204 skip -> 208
        handshake(0, 1'b1, 1'b1, 12'h300);    // 208 jump wins -> 300
        handshake(0, 1'b0, 1'b1, 12'hFFE);    // 300 -> FFE
        handshake(0, 1'b0, 1'b0, 12'h000);    // FFE (1234) -> 000
        handshake(0, 1'b0, 1'b1, 12'hFFE);    // 000 -> FFE
        handshake(0, 1'b1, 1'b0, 12'h000);    // FFE skip -> 002
        handshake(0, 1'b0, 1'b1, 12'hFFF);    // 002 -> FFF
        handshake(0, 1'b0, 1'b0, 12'h000);    // FFF/000 -> 001
        handshake(0, 1'b0, 1'b1, 12'h301);    // 001 -> 301 (odd)
        handshake(0, 1'b0, 1'b0, 12'h000);    // 301/302 -> 303

        @(posedge clk); #1;                   // now in ISSUE_LO
        do_reset();
        handshake(0, 1'b0, 1'b0, 12'h000);
        wait_valid();                         // reset while VALID
        do_reset();

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, 5)) begin
                    junk(1'b0);
                    @(posedge clk); #1;
                end
                do_reset();
            end else begin
                handshake(int'($urandom_range(0, 3)), 1'($urandom),
                          $urandom_range(0, 3) == 0, 12'($urandom));
            end
        end

        wait_valid();
        repeat (2) @(posedge clk);
        finish_sim();
    end
endmodule
